// File: rtl/runup_result_reader.sv
// Snapshots the runs-up counter bank and sample total on start, then streams the frozen
// copy as 32-bit words (header, total, counters) over a valid/ready interface.
module runup_result_reader #(
    parameter int unsigned NUM_BINS = 32,
    parameter logic [31:0] HEADER   = 32'h52554E55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] cnt [NUM_BINS-1:0],
    input  logic [63:0] total,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned FRAME_LEN = 3 + 2 * NUM_BINS;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned BIN_W     = IDX_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_load;

    logic [63:0]      r_snap_total;
    logic [63:0]      r_snap_cnt [NUM_BINS-1:0];

    logic [IDX_W-1:0] w_off;
    logic [BIN_W-1:0] w_bin;
    logic [63:0]      w_cnt_sel;
    logic [31:0]      w_word;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StSend;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            StSend: begin
                if (dout_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = StIdle;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Frozen copy; the live inputs keep counting while this drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_total <= '0;
            for (int k = 0; k < NUM_BINS; k++) begin
                r_snap_cnt[k] <= '0;
            end
        end else if (w_load) begin
            r_snap_total <= total;
            for (int k = 0; k < NUM_BINS; k++) begin
                r_snap_cnt[k] <= cnt[k];
            end
        end
    end

    // Counter words start at index 3; w_off is meaningless (and unused) below that.
    assign w_off = r_idx - IDX_W'(3);
    assign w_bin = w_off[IDX_W-1:1];

    always_comb begin
        w_cnt_sel = '0;
        for (int k = 0; k < NUM_BINS; k++) begin
            if (w_bin == BIN_W'(k)) begin
                w_cnt_sel = r_snap_cnt[k];
            end
        end
    end

    always_comb begin
        w_word = '0;
        if (r_idx == IDX_W'(0)) begin
            w_word = HEADER;
        end else if (r_idx == IDX_W'(1)) begin
            w_word = r_snap_total[31:0];
        end else if (r_idx == IDX_W'(2)) begin
            w_word = r_snap_total[63:32];
        end else if (w_off[0]) begin
            w_word = w_cnt_sel[63:32];
        end else begin
            w_word = w_cnt_sel[31:0];
        end
    end

    assign busy       = (r_state == StSend);
    assign dout_valid = busy;
    assign dout_last  = busy && (r_idx == LAST_IDX);
    assign dout       = busy ? w_word : '0;
    assign done       = r_done;

endmodule

// File: tb/tb_runup_result_reader.sv
// Directed bench for runup_result_reader: spot-check table plus a frame model compared
// word by word, with sequences for backpressure, isolation, start-while-busy and reset.
module tb_runup_result_reader;

    localparam int NB = 32;
    localparam int FL = 3 + 2 * NB;
    localparam logic [31:0] HDR = 32'h52554E55;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] cnt [NB-1:0];
    logic [63:0] total;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        busy;
    logic        done;

    runup_result_reader #(
        .NUM_BINS(NB),
        .HEADER  (HDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cnt       (cnt),
        .total     (total),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          frame;
        int          idx;
        logic [31:0] word;
        logic        last;
    } vec_t;

    vec_t        vecs [15];
    logic [63:0] s_cnt [NB-1:0];
    logic [63:0] s_total;
    logic [31:0] got [FL];
    logic        got_last [FL];
    int          n_got;
    int          n_total = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i);
        logic [63:0] w;
        if (i == 0) return HDR;
        if (i == 1) return s_total[31:0];
        if (i == 2) return s_total[63:32];
        w = s_cnt[(i - 3) / 2];
        return ((i - 3) % 2 == 1) ? w[63:32] : w[31:0];
    endfunction

    task automatic set_basic();
        total = 64'h0000_0001_0000_0004;
        for (int k = 0; k < NB; k++) cnt[k] = 64'(k + 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
        chk({tag, "_last"}, 64'(dout_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_dout"}, 64'(dout), 64'd0);
    endtask

    // Called at a negedge while idle; returns at the negedge of cycle N+1.
    task automatic do_start();
        s_total = total;
        for (int k = 0; k < NB; k++) s_cnt[k] = cnt[k];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_valid", 64'(dout_valid), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_hdr", 64'(dout), 64'(HDR));
        chk("start_last", 64'(dout_last), 64'd0);
    endtask

    // Drains one frame; returns at the negedge of the cycle after the final transfer.
    task automatic drain(input int pct, input bit scramble, input bit busy_start);
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [31:0] pdout = '0;
        logic        plast = 1'b0;
        n_got = 0;
        while (n_got < FL) begin
            if (cyc > 4000) begin
                chk("drain_timeout", 64'(n_got), 64'(FL));
                break;
            end
            chk("mid_done", 64'(done), 64'd0);
            chk("mid_valid", 64'(dout_valid), 64'd1);
            chk("mid_busy", 64'(busy), 64'd1);
            if (stalled) begin
                chk("stall_dout", 64'(dout), 64'(pdout));
                chk("stall_last", 64'(dout_last), 64'(plast));
            end
            start = 1'b0;
            dout_ready = ($urandom_range(99) < pct);
            stalled = !dout_ready;
            pdout = dout;
            plast = dout_last;
            if (dout_ready) begin
                got[n_got] = dout;
                got_last[n_got] = dout_last;
                n_got++;
                if (busy_start && (n_got == 10 || n_got == FL)) start = 1'b1;
            end
            if (scramble) begin
                total = {$urandom, $urandom};
                for (int k = 0; k < NB; k++) cnt[k] = {$urandom, $urandom};
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        dout_ready = 1'($urandom_range(1));
        chk("end_done", 64'(done), 64'd1);
        check_idle("end");
        for (int i = 0; i < n_got; i++) begin
            chk($sformatf("word%0d", i), 64'(got[i]), 64'(exp_word(i)));
            chk($sformatf("last%0d", i), 64'(got_last[i]), 64'(i == FL - 1));
        end
    endtask

    task automatic spot(input int frame);
        for (int v = 0; v < 15; v++) begin
            if (vecs[v].frame == frame) begin
                chk($sformatf("spot%0d_w%0d", frame, vecs[v].idx),
                    64'(got[vecs[v].idx]), 64'(vecs[v].word));
                chk($sformatf("spot%0d_l%0d", frame, vecs[v].idx),
                    64'(got_last[vecs[v].idx]), 64'(vecs[v].last));
            end
        end
    endtask

    initial begin
        vecs[0]  = '{0, 0, 32'h52554E55, 1'b0};
        vecs[1]  = '{0, 1, 32'h00000004, 1'b0};
        vecs[2]  = '{0, 2, 32'h00000001, 1'b0};
        vecs[3]  = '{0, 3, 32'h00000001, 1'b0};
        vecs[4]  = '{0, 4, 32'h00000000, 1'b0};
        vecs[5]  = '{0, 5, 32'h00000002, 1'b0};
        vecs[6]  = '{0, 6, 32'h00000000, 1'b0};
        vecs[7]  = '{0, 65, 32'h00000020, 1'b0};
        vecs[8]  = '{0, 66, 32'h00000000, 1'b1};
        vecs[9]  = '{1, 0, 32'h52554E55, 1'b0};
        vecs[10] = '{1, 1, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{1, 2, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{1, 3, 32'h00000001, 1'b0};
        vecs[13] = '{1, 65, 32'hFFFFFFFF, 1'b0};
        vecs[14] = '{1, 66, 32'hFFFFFFFF, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        dout_ready = 1'b0;
        total = '0;
        for (int k = 0; k < NB; k++) cnt[k] = '0;
        #1;
        check_idle("rst");
        chk("rst_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        // Basic frame
        set_basic();
        do_start();
        drain(100, 1'b0, 1'b0);
        spot(0);
        @(negedge clk);
        chk("basic_done_once", 64'(done), 64'd0);
        check_idle("basic_after");

        // Backpressure
        do_start();
        drain(40, 1'b0, 1'b0);
        spot(0);
        @(negedge clk);

        // Snapshot isolation
        do_start();
        drain(70, 1'b1, 1'b0);
        @(negedge clk);

        // Start while busy, including at the final-transfer edge
        set_basic();
        do_start();
        drain(100, 1'b0, 1'b1);
        spot(0);
        @(negedge clk);
        chk("busy_start_done", 64'(done), 64'd0);
        check_idle("busy_start_ignored");

        // Back-to-back: start sampled one edge after the final transfer
        do_start();
        drain(100, 1'b0, 1'b0);
        do_start();
        drain(100, 1'b0, 1'b0);
        spot(0);
        @(negedge clk);

        // Reset mid-frame
        do_start();
        dout_ready = 1'b1;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle("abort");
        chk("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_done", 64'(done), 64'd0);
            chk("abort_hold_valid", 64'(dout_valid), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_release");
        chk("abort_release_done", 64'(done), 64'd0);
        do_start();
        drain(100, 1'b0, 1'b0);
        spot(0);
        @(negedge clk);

        // Max values
        set_basic();
        total = 64'hFFFF_FFFF_FFFF_FFFF;
        cnt[NB-1] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_start();
        drain(100, 1'b0, 1'b0);
        spot(1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/runup_result_reader.md
# runup_result_reader

Read-out engine for the runs-up statistic block. On a start pulse it snapshots the runs-up counter bank and the sample total. It then streams the snapshot as 32-bit words over a valid/ready interface to the host-side transport (UART/PCIe bridge FIFO). The statistic block keeps counting undisturbed while the frozen copy is being drained.

## Interface
Parameters:
- NUM_BINS, 32: number of 64-bit run counters read out.
- HEADER, 32'h52554E55: word sent first in every frame ("RUNU").

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to snapshot and send one frame.
- cnt  input  64 x NUM_BINS (unpacked [NUM_BINS-1:0])  live run counters.
- total  input  64  live count of samples consumed.
- dout  output  32  frame word.
- dout_valid  output  1  dout holds a valid word.
- dout_ready  input  1  sink accepts dout this cycle.
- dout_last  output  1  high with the final word of a frame.
- busy  output  1  a frame is pending or in transfer.
- done  output  1  one-cycle pulse after the final word transfers.

## Operation
- State machine: IDLE -> SEND -> IDLE.
- IDLE:
  - If start=1 on a clock edge, latch cnt[0..NUM_BINS-1] and total into snapshot registers.
  - Clear the word index to 0 and go to SEND.
  - start is ignored outside IDLE; no queuing.
- Frame order is fixed, FRAME_LEN = 3 + 2*NUM_BINS words (67 at default):
  - index 0: HEADER
  - index 1: total[31:0]
  - index 2: total[63:32]
  - index 3+2k: cnt[k][31:0]
  - index 4+2k: cnt[k][63:32], for k = 0..NUM_BINS-1
- SEND:
  - dout_valid=1 and dout = word[index].
  - A transfer occurs on any edge with dout_valid & dout_ready. The index then increments.
  - dout_last=1 exactly when index = FRAME_LEN-1.
  - The transfer of the last word returns to IDLE and sets done=1 for the following cycle.
- Snapshot registers change only on an accepted start. Live input changes during SEND never alter the words being sent.
- busy=1 while in SEND, 0 in IDLE.
- The index counter is sized ceil(log2(FRAME_LEN)) bits and never wraps inside a frame.

## Timing
- Reset values: dout=0, dout_valid=0, dout_last=0, busy=0, done=0, state=IDLE, index=0, snapshot=0.
- Reset asserted mid-frame aborts the frame immediately, with no done pulse. After release the block is in IDLE.
- start at edge N gives dout_valid=1 with HEADER and busy=1 from cycle N+1.
- Throughput is one word per cycle while dout_ready stays high. A full frame takes FRAME_LEN cycles after start.
- While dout_valid=1 and dout_ready=0, dout and dout_last hold stable, and dout_valid does not drop until the transfer completes.
- After the final transfer at edge M:
  - dout_valid=0, dout_last=0 and busy=0 from cycle M+1.
  - done=1 only in cycle M+1.
- A start sampled at edge M+1 is accepted, so frames can run back-to-back with one idle cycle between them.
- start at the same edge as the final transfer is ignored, because the state is still SEND at that edge.
- dout_ready toggling while dout_valid=0 has no effect.

## Test plan
- Basic frame:
  - Stimulus: reset, total=64'h0000_0001_0000_0004, cnt[k]=k+1 (upper halves 0), start pulse, dout_ready=1.
  - Required: 67 consecutive words 52554E55, 00000004, 00000001, 00000001, 00000000, 00000002, ... 00000020, 00000000.
  - Required: dout_last only on word 67, done one cycle later, busy=0 afterwards.
- Backpressure:
  - Stimulus: dout_ready random at ~40% duty.
  - Required: the same 67-word sequence with no drops or duplicates, and dout stable across every stalled cycle.
- Snapshot isolation:
  - Stimulus: change total and all cnt every cycle after start.
  - Required: the frame carries only the values present at the start edge.
- Start while busy:
  - Stimulus: pulse start at words 10 and 67 (the final-transfer edge).
  - Required: both pulses are ignored, and one frame ends with one done pulse.
  - Stimulus: start one cycle after done.
  - Required: a new frame begins with HEADER.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously (between edges) after word 20.
  - Required: all outputs go to 0 immediately, and no done pulse.
  - Stimulus: start after release.
  - Required: a full frame from HEADER.
- Max values:
  - Stimulus: cnt[31]=64'hFFFF_FFFF_FFFF_FFFF, total=64'hFFFF_FFFF_FFFF_FFFF.
  - Required: words 2-3 and 66-67 are FFFFFFFF.
